// File: rtl/timer_pkg.sv
// Shared encodings and BCD helpers for the countdown timer controller.
package timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam int CLK_PER_SEC_DEF = 125000000;

  // Clamp a {tens,ones} BCD byte into 00..59.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    logic [3:0] t, o;
    t = (v[7:4] > TENS_MAX) ? TENS_MAX : v[7:4];
    o = (v[3:0] > ONES_MAX) ? ONES_MAX : v[3:0];
    return {t, o};
  endfunction
endpackage

// File: rtl/bcd_mmss_down.sv
// Loadable MM:SS BCD down-counter; clamps loads and stops at 00:00.
module bcd_mmss_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_p,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       dec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       is_zero
);
  logic [7:0] r_min, r_sec;
  logic       w_b0, w_b1, w_b2;
  logic [3:0] w_so, w_st, w_mo, w_mt;

  // Borrow ripples ones -> tens -> minute ones -> minute tens.
  assign w_b0 = (r_sec[3:0] == 4'd0);
  assign w_so = w_b0 ? ONES_MAX : r_sec[3:0] - 4'd1;
  assign w_b1 = w_b0 && (r_sec[7:4] == 4'd0);
  assign w_st = !w_b0 ? r_sec[7:4] : (r_sec[7:4] == 4'd0) ? TENS_MAX : r_sec[7:4] - 4'd1;
  assign w_b2 = w_b1 && (r_min[3:0] == 4'd0);
  assign w_mo = !w_b1 ? r_min[3:0] : (r_min[3:0] == 4'd0) ? ONES_MAX : r_min[3:0] - 4'd1;
  assign w_mt = !w_b2 ? r_min[7:4] : (r_min[7:4] == 4'd0) ? TENS_MAX : r_min[7:4] - 4'd1;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_min <= 8'h00;
      r_sec <= 8'h00;
    end else if (load) begin
      r_min <= bcd_clamp(load_min);
      r_sec <= bcd_clamp(load_sec);
    end else if (dec && !is_zero) begin
      r_min <= {w_mt, w_mo};
      r_sec <= {w_st, w_so};
    end
  end

  assign is_zero = (r_min == 8'h00) && (r_sec == 8'h00);
  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: 1 s prescaler, run/pause/alarm FSM, alarm duration.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC   = CLK_PER_SEC_DEF,
  parameter int ALARM_LEN_SEC = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_start_stop,
  input  logic       btn_load,
  input  logic       btn_clear,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);
  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [5:0]    ALM_MAX = 6'(ALARM_LEN_SEC - 1);

  state_t        r_state, w_nstate;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_acnt;
  logic          r_running, r_alarm;
  logic          w_tick, w_load, w_cnt_load, w_dec, w_is_zero, w_one_left;
  logic [7:0]    w_ld_min, w_ld_sec, w_min, w_sec;

  assign w_tick     = ((r_state == ST_RUN) || (r_state == ST_ALARM)) && (r_presc == PRE_MAX);
  assign w_one_left = (w_min == 8'h00) && (w_sec == 8'h01);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= ST_IDLE;
    else         r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    if (btn_clear) w_nstate = ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE:  if (btn_start_stop && !w_is_zero) w_nstate = ST_RUN;
        // A tick reaching 00:00 overrides a simultaneous pause.
        ST_RUN:   if (w_tick && w_one_left) w_nstate = ST_ALARM;
                  else if (btn_start_stop)  w_nstate = ST_PAUSE;
        ST_PAUSE: if (btn_start_stop) w_nstate = w_is_zero ? ST_IDLE : ST_RUN;
        ST_ALARM: if (btn_start_stop || (w_tick && r_acnt == ALM_MAX)) w_nstate = ST_IDLE;
        default:  w_nstate = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load     = !btn_clear && !btn_start_stop && btn_load &&
                 ((r_state == ST_IDLE) || (r_state == ST_PAUSE));
    w_cnt_load = btn_clear || w_load;
    w_ld_min   = btn_clear ? 8'h00 : set_min;
    w_ld_sec   = btn_clear ? 8'h00 : set_sec;
    w_dec      = !btn_clear && (r_state == ST_RUN) && w_tick;
  end

  // Prescaler sits at 0 in IDLE so every start begins a full second; PAUSE holds it.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      r_presc <= '0;
    else if (btn_clear || (r_state == ST_IDLE) ||
             ((r_state == ST_RUN) && (w_nstate == ST_ALARM)))
      r_presc <= '0;
    else if ((r_state == ST_RUN) || (r_state == ST_ALARM))
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      r_acnt <= 6'd0;
    else if ((r_state != ST_ALARM) || (w_nstate != ST_ALARM))
      r_acnt <= 6'd0;
    else if (w_tick)
      r_acnt <= r_acnt + 6'd1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_running <= (w_nstate == ST_RUN);
      r_alarm   <= (w_nstate == ST_ALARM);
    end
  end

  bcd_mmss_down u_cnt (
    .clk      (clk),
    .reset_p  (reset_p),
    .load     (w_cnt_load),
    .load_min (w_ld_min),
    .load_sec (w_ld_sec),
    .dec      (w_dec),
    .min_bcd  (w_min),
    .sec_bcd  (w_sec),
    .is_zero  (w_is_zero)
  );

  assign min_bcd = w_min;
  assign sec_bcd = w_sec;
  assign running = r_running;
  assign alarm   = r_alarm;
  assign state   = r_state;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed plan plus random button traffic against a seconds-based reference model.
module tb_countdown_timer_ctrl;
  localparam int CPS  = 10;
  localparam int ALEN = 3;

  logic       clk = 1'b0, reset_p = 1'b1;
  logic       btn_start_stop = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
  logic [7:0] set_min = 8'h00, set_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, alarm;
  logic [1:0] state;
  int         checks = 0, errors = 0;

  countdown_timer_ctrl #(.CLK_PER_SEC(CPS), .ALARM_LEN_SEC(ALEN)) dut (
    .clk(clk), .reset_p(reset_p), .btn_start_stop(btn_start_stop), .btn_load(btn_load),
    .btn_clear(btn_clear), .set_min(set_min), .set_sec(set_sec), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .running(running), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  // Model: state number, remaining time in whole seconds, prescaler, alarm seconds.
  typedef struct packed { logic [1:0] st; int t; int pre; int ac; } mdl_t;
  mdl_t m;

  function automatic int dig(input logic [3:0] d, input int lim);
    return (int'(d) > lim) ? lim : int'(d);
  endfunction

  function automatic int ldval(input logic [7:0] mn, input logic [7:0] sc);
    return (dig(mn[7:4], 5) * 10 + dig(mn[3:0], 9)) * 60 + dig(sc[7:4], 5) * 10 + dig(sc[3:0], 9);
  endfunction

  function automatic logic [7:0] bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic mdl_t nxt(input mdl_t c, input logic clr, input logic ss, input logic ld,
                               input logic [7:0] smin, input logic [7:0] ssec);
    mdl_t n = c;
    logic tk;
    tk = (c.st == 2'd1 || c.st == 2'd3) && c.pre == CPS - 1;
    if (c.st == 2'd1 || c.st == 2'd3) n.pre = (c.pre + 1) % CPS;
    if (clr) begin
      n.st = 2'd0; n.t = 0; n.pre = 0; n.ac = 0;
      return n;
    end
    case (c.st)
      2'd0: if (ss) begin
              if (c.t != 0) begin n.st = 2'd1; n.pre = 0; end
            end else if (ld) n.t = ldval(smin, ssec);
      2'd1: begin
              if (tk) n.t = c.t - 1;
              if (tk && n.t == 0) begin n.st = 2'd3; n.pre = 0; n.ac = 0; end
              else if (ss) n.st = 2'd2;
            end
      2'd2: if (ss) n.st = (c.t == 0) ? 2'd0 : 2'd1;
            else if (ld) n.t = ldval(smin, ssec);
      default: if (ss) begin n.st = 2'd0; n.pre = 0; n.ac = 0; end
               else if (tk) begin
                 if (c.ac + 1 == ALEN) begin n.st = 2'd0; n.pre = 0; n.ac = 0; end
                 else n.ac = c.ac + 1;
               end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) m <= '0;
    else         m <= nxt(m, btn_clear, btn_start_stop, btn_load, set_min, set_sec);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set at the previous negedge; release buttons and compare.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    btn_start_stop = 1'b0; btn_load = 1'b0; btn_clear = 1'b0;
    chk("mdl_state", 32'(state), 32'(m.st));
    chk("mdl_time", {16'h0, min_bcd, sec_bcd}, {16'h0, bcd(m.t / 60), bcd(m.t % 60)});
    chk("mdl_flags", {30'h0, running, alarm}, {30'h0, m.st == 2'd1, m.st == 2'd3});
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    set_min = mn; set_sec = sc; btn_load = 1'b1; cyc();
  endtask

  task automatic press_ss();   btn_start_stop = 1'b1; cyc(); endtask
  task automatic press_clr();  btn_clear = 1'b1;      cyc(); endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", {19'h0, min_bcd, sec_bcd, running, alarm, state}, 32'h0);
    reset_p = 1'b0;
    cyc();

    // 01:00 -> 00:59 after one second
    do_load(8'h01, 8'h00); press_ss();
    repeat (CPS) cyc();
    chk("t1_time", {min_bcd, sec_bcd}, 16'h0059);
    chk("t1_state", state, 2'd1);
    press_clr();

    // 00:02 -> alarm -> auto idle after ALEN seconds
    do_load(8'h00, 8'h02); press_ss();
    repeat (CPS) cyc();
    chk("t2_one", {min_bcd, sec_bcd}, 16'h0001);
    repeat (CPS) cyc();
    chk("t2_zero", {min_bcd, sec_bcd, state, alarm}, {16'h0000, 2'd3, 1'b1});
    repeat (ALEN * CPS - 1) cyc();
    chk("t2_alarm_hold", alarm, 1'b1);
    cyc();
    chk("t2_idle", {state, alarm}, {2'd0, 1'b0});

    // pause holds the prescaler
    do_load(8'h00, 8'h05); press_ss();
    repeat (4) cyc();
    press_ss();
    repeat (50) cyc();
    chk("t3_paused", {min_bcd, sec_bcd, state}, {16'h0005, 2'd2});
    press_ss();
    repeat (4) cyc();
    chk("t3_before", {min_bcd, sec_bcd}, 16'h0005);
    cyc();
    chk("t3_after", {min_bcd, sec_bcd}, 16'h0004);
    press_clr();

    // clamping and multi-digit borrow
    do_load(8'h7A, 8'h6F);
    chk("t4_clamp", {min_bcd, sec_bcd}, 16'h5959);
    press_ss();
    repeat (CPS) cyc();
    chk("t4_dec", {min_bcd, sec_bcd}, 16'h5958);
    press_clr();
    do_load(8'h10, 8'h00); press_ss();
    repeat (CPS) cyc();
    chk("t4_borrow", {min_bcd, sec_bcd}, 16'h0959);
    press_clr();

    // start at 00:00 ignored; clear beats start
    press_ss();
    chk("t5_idle_zero", state, 2'd0);
    do_load(8'h00, 8'h03); press_ss(); repeat (3) cyc();
    btn_clear = 1'b1; btn_start_stop = 1'b1; cyc();
    chk("t5_clr_ss", {min_bcd, sec_bcd, state}, {16'h0000, 2'd0});

    // pause, load 00:00, start -> idle
    do_load(8'h00, 8'h09); press_ss(); press_ss();
    do_load(8'h00, 8'h00); press_ss();
    chk("t6_pause_zero", state, 2'd0);

    // pause on the final tick: alarm wins
    do_load(8'h00, 8'h01); press_ss();
    repeat (CPS - 1) cyc();
    press_ss();
    chk("t7_alarm_wins", {state, alarm}, {2'd3, 1'b1});

    // asynchronous reset mid-alarm
    cyc();
    #2 reset_p = 1'b1;
    #1 chk("t8_async", {19'h0, min_bcd, sec_bcd, running, alarm, state}, 32'h0);
    @(negedge clk);
    reset_p = 1'b0;
    repeat (3) cyc();
    chk("t8_stay_idle", state, 2'd0);

    // random traffic, at most one button per cycle
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 99);
      set_min = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      set_sec = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      if (r < 3)       btn_start_stop = 1'b1;
      else if (r < 6)  btn_load = 1'b1;
      else if (r == 6) btn_clear = 1'b1;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
